// File: rtl/io_bank.sv
// MMIO responder: GPIO, 32-bit compare timer (IO_TIMER_EN) and a TX byte FIFO.
// Reads are combinational from io_addr; writes commit at the clock edge.
module io_bank #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FIFO_DEPTH_LOG = 3,
    parameter int GPIO_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic [7:0]            io_addr,
    input  logic                  io_en,
    input  logic                  io_we,
    input  logic [31:0]           io_data_write,
    output logic [31:0]           io_data_read,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  timer_irq
);

    localparam int CW = FIFO_DEPTH_LOG + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [5:0] A_GPIO_OUT = 6'h00;
    localparam logic [5:0] A_GPIO_IN  = 6'h01;
    localparam logic [5:0] A_CNT      = 6'h02;
    localparam logic [5:0] A_CMP      = 6'h03;
    localparam logic [5:0] A_CTRL     = 6'h04;
    localparam logic [5:0] A_TXD      = 6'h08;
    localparam logic [5:0] A_TXS      = 6'h09;

    logic [5:0] w_word;
    logic       w_wr;
    logic       w_rd;

    assign w_word = io_addr[7:2];
    assign w_wr   = io_en && io_we;
    assign w_rd   = io_en && !io_we;

    logic [GPIO_WIDTH-1:0] r_gpio_out;
    logic [GPIO_WIDTH-1:0] r_gpio_s1;
    logic [GPIO_WIDTH-1:0] r_gpio_s2;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_gpio_out <= '0;
            r_gpio_s1  <= '0;
            r_gpio_s2  <= '0;
        end else begin
            r_gpio_s1 <= gpio_in;
            r_gpio_s2 <= r_gpio_s1;
            if (w_wr && w_word == A_GPIO_OUT)
                r_gpio_out <= io_data_write[GPIO_WIDTH-1:0];
        end
    end

    assign gpio_out = r_gpio_out;

    logic [7:0]                r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG-1:0] r_rd_ptr;
    logic [CW-1:0]             r_count;
    logic                      r_ovf;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_push_req;
    logic                      w_push;
    logic                      w_pop;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_push_req = w_wr && (w_word == A_TXD);
    assign w_push     = w_push_req && !w_full;
    assign w_pop      = !w_empty && tx_ready;

    // Storage needs no reset: the occupancy counter gates visibility.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= io_data_write[7:0];
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full)
                r_ovf <= 1'b1;
            else if (w_wr && w_word == A_TXS && io_data_write[2])
                r_ovf <= 1'b0;
        end
    end

    assign tx_valid = !w_empty;
    assign tx_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];

`ifdef IO_TIMER_EN
    logic [31:0] r_cnt;
    logic [31:0] r_cmp;
    logic [2:0]  r_ctrl;
    logic        r_flag;
    logic        r_irq;
    logic        w_match;

    assign w_match = r_ctrl[0] && (r_cnt == r_cmp);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_cnt  <= '0;
            r_cmp  <= '1;
            r_ctrl <= '0;
            r_flag <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && w_word == A_CNT)
                r_cnt <= io_data_write;
            else if (r_ctrl[0])
                r_cnt <= (w_match && r_ctrl[1]) ? 32'h0 : r_cnt + 32'h1;
            if (w_wr && w_word == A_CMP)
                r_cmp <= io_data_write;
            if (w_wr && w_word == A_CTRL)
                r_ctrl <= io_data_write[2:0];
            // A new match outranks a same-edge software clear.
            if (w_match)
                r_flag <= 1'b1;
            else if (w_wr && w_word == A_CTRL && io_data_write[8])
                r_flag <= 1'b0;
            r_irq <= r_flag && r_ctrl[2];
        end
    end

    assign timer_irq = r_irq;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        io_data_read = '0;
        if (w_rd) begin
            case (w_word)
                A_GPIO_OUT: io_data_read = 32'(r_gpio_out);
                A_GPIO_IN:  io_data_read = 32'(r_gpio_s2);
`ifdef IO_TIMER_EN
                A_CNT:      io_data_read = r_cnt;
                A_CMP:      io_data_read = r_cmp;
                A_CTRL:     io_data_read = {23'h0, r_flag, 5'h0, r_ctrl};
`endif
                A_TXS: begin
                    io_data_read[8 +: CW] = r_count;
                    io_data_read[2:0]     = {r_ovf, w_empty, w_full};
                end
                default:    io_data_read = '0;
            endcase
        end
    end

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, io_addr[1:0], io_data_write};

endmodule

// File: doc/io_bank.md
# io_bank

Memory-mapped I/O responder on the MMU's I/O port (data-side window 0x80000000–0x800000FF). It decodes the MMU's registered `io_addr`/`io_en`/`io_we`/`io_data_write` strobes and returns `io_data_read` in the same cycle. It implements:
- a GPIO output/input register pair;
- a 32-bit timer with compare and interrupt;
- a byte-wide transmit FIFO drained over a valid/ready handshake toward a serial or console sink.

## Interface
Parameters:
- `FIFO_DEPTH`, 8, TX FIFO entries (power of two)
- `FIFO_DEPTH_LOG`, 3, log2(`FIFO_DEPTH`)
- `GPIO_WIDTH`, 8, GPIO in/out width (≤ 32)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `resetb`  in  1  asynchronous active-low reset
- `io_addr`  in  8  byte offset within the I/O window
- `io_en`  in  1  access strobe for this cycle
- `io_we`  in  1  write strobe, qualified by `io_en`
- `io_data_write`  in  32  write data
- `io_data_read`  out  32  read data, combinational from `io_addr`
- `gpio_in`  in  `GPIO_WIDTH`  asynchronous external inputs
- `gpio_out`  out  `GPIO_WIDTH`  registered outputs
- `tx_data`  out  8  FIFO head byte
- `tx_valid`  out  1  FIFO non-empty
- `tx_ready`  in  1  sink accepts head this cycle
- `timer_irq`  out  1  registered timer interrupt

## Operation
- Decode uses `io_addr[7:2]`; bits [1:0] are ignored. All registers are accessed as full 32-bit words, so software uses `lw`/`sw` only.
- Write: `io_en && io_we` at a rising edge commits `io_data_write` to the addressed register.
- Read: while `io_en && !io_we`, `io_data_read` holds the addressed register. With `io_en` low, `io_data_read` = 0.
- Reads have no side effects.
- Unmapped offsets read 0; writes to them are ignored.
- Register map:
  - 0x00 GPIO_OUT, RW, [`GPIO_WIDTH`-1:0] drive `gpio_out`.
  - 0x04 GPIO_IN, RO: `gpio_in` after a two-flop synchronizer, zero-extended.
  - 0x08 TIMER_COUNT, RW.
  - 0x0C TIMER_CMP, RW.
  - 0x10 TIMER_CTRL:
    - bit0 enable
    - bit1 clear-on-match
    - bit2 irq enable
    - bit8 match flag, RO, write-1-clears
  - 0x20 TX_DATA, WO: `io_data_write[7:0]` is pushed; reads return 0.
  - 0x24 TX_STATUS:
    - bit0 full
    - bit1 empty
    - bit2 overflow, sticky, write-1-clears
    - [8+:`FIFO_DEPTH_LOG`+1] occupancy
- Timer:
  - While enabled, COUNT increments each cycle and wraps 0xFFFFFFFF→0.
  - When COUNT == CMP and enable is set: match flag is set. COUNT loads 0 next if clear-on-match is set, otherwise it increments.
  - A software write to COUNT overrides the increment/clear for that edge.
  - If a flag set and a W1C land on the same edge, set wins.
  - `timer_irq` <= flag & irq-enable.
- TX FIFO:
  - Circular buffer with read/write pointers and an occupancy counter.
  - Push happens on a TX_DATA write when not full. A push while full is dropped and sets overflow. Fullness is sampled before the edge, so a pop on the same edge does not rescue the push.
  - Pop happens when `tx_valid && tx_ready`.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves occupancy unchanged.
  - A push into an empty FIFO makes `tx_valid` high the next cycle, never the same cycle.
  - `tx_data` is the head entry when valid, otherwise 0.

## Timing
- Reset values:
  - `gpio_out` = 0, GPIO sync flops = 0
  - `tx_valid` = 0, `tx_data` = 0
  - `timer_irq` = 0
  - COUNT = 0, CMP = 0xFFFFFFFF, CTRL = 0
  - FIFO empty, overflow = 0
- `io_data_read`: zero-cycle combinational path from `io_addr`/`io_en`/`io_we`. The MMU samples it in the cycle after it registers the request.
- Write latency: the register is updated at the edge where `io_en && io_we`. A read of that register in the next cycle returns the new value.
- GPIO_IN latency is 2 cycles from a `gpio_in` change.
- `timer_irq` asserts 1 cycle after the flag sets, and deasserts 1 cycle after the flag clears.
- FIFO pointer wrap is modulo `FIFO_DEPTH`. Occupancy spans 0..`FIFO_DEPTH`.
- Reset asserted mid-operation clears all state immediately, including queued FIFO bytes.

## Configuration
- `IO_TIMER_EN` defined: timer, TIMER_* registers and `timer_irq` are present as specified above.
- `IO_TIMER_EN` undefined: no timer logic. Offsets 0x08–0x10 read 0 and ignore writes. `timer_irq` is tied to 0.

## Test plan
- Write 0x000000A5 to 0x00 -> `gpio_out` = 0xA5 after that edge; read 0x00 next cycle returns 0x000000A5.
- Drive `gpio_in` = 0x3C -> read 0x04 returns 0x0000003C from the second edge onward; returns 0 before that.
- CMP = 4, CTRL = 0x7 -> count sequence 0,1,2,3,4,0,…; flag set at the count==4 edge; `timer_irq` high one cycle later. Write 0x100 to 0x10 -> irq low one cycle after the flag clears.
- Push 9 bytes 0x01..0x09 with `tx_ready` = 0 -> status full = 1, occupancy 8, overflow = 1. Raise `tx_ready` -> `tx_data` emits 0x01..0x08 on consecutive cycles, then `tx_valid` = 0.
- With FIFO holding 3 bytes and `tx_ready` = 1, push 0x55 on the same edge as a pop -> occupancy stays 3; 0x55 emerges fourth.
- Assert `resetb` low while FIFO is non-empty and timer is running -> all outputs return to reset values immediately; status reads empty = 1, occupancy 0.
